// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS main controller:
//   - state_t      : controller state encoding (FETCH..JUMP)
//   - OP_*         : supported opcodes (6-bit MIPS primary opcode field)
//   - ALUOP_*      : ALU operation select codes
//   - ALUSRCB_*    : ALU B-operand select codes
//   - PCSRC_*      : PC source select codes
//   - ctrl_t       : packed control vector driven to the datapath
//   - op_legal()   : opcode support check honouring the optional opcodes
//   - ctrl_gate()  : clears every architectural write strobe in a vector
// -----------------------------------------------------------------------------
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       illegal_op;
    } ctrl_t;

    // Opcode support check; BNE and ORI depend on the build options.
    function automatic logic op_legal(input logic [5:0] op,
                                      input logic       en_bne,
                                      input logic       en_ori);
        logic ok;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            OP_BNE:  ok = en_bne;
            OP_ORI:  ok = en_ori;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Drop every strobe that could change architectural state.
    function automatic ctrl_t ctrl_gate(input ctrl_t c);
        ctrl_t g;
        g          = c;
        g.pcen     = 1'b0;
        g.irwrite  = 1'b0;
        g.memwrite = 1'b0;
        g.regwrite = 1'b0;
        return g;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// -----------------------------------------------------------------------------
// mc_outdec
// Combinational output decoder: maps the controller state (plus the opcode
// and memory-ready where the output depends on them) to the control vector.
// Ports:
//   i_state     current controller state
//   i_op6       opcode from the instruction register
//   i_legal     opcode is supported in this build
//   i_zero      ALU zero flag
//   i_mem_ready effective memory-ready (already forced high when unused)
//   o_ctrl      control vector for the datapath
// -----------------------------------------------------------------------------
module mc_outdec
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op6,
    input  logic       i_legal,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    logic w_pcwrite;
    logic w_branch;
    logic w_is_bne;
    logic w_is_ori;

    assign w_is_bne = (i_op6 == OP_BNE);
    assign w_is_ori = (i_op6 == OP_ORI);

    // Per-state control values; anything not set for a state stays 0.
    always_comb begin
        o_ctrl    = '0;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        case (i_state)
            FETCH: begin
                o_ctrl.alusrcb = ALUSRCB_FOUR;
                // IR and PC only load once the fetch data is actually there.
                o_ctrl.irwrite = i_mem_ready;
                w_pcwrite      = i_mem_ready;
            end
            DECODE: begin
                o_ctrl.alusrcb    = ALUSRCB_IMMSH;
                o_ctrl.illegal_op = ~i_legal;
            end
            MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
            end
            MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            MEMWB: begin
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.pcsrc   = PCSRC_ALUOUT;
                w_branch       = 1'b1;
            end
            IMMEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
                o_ctrl.aluop   = w_is_ori ? ALUOP_OR : ALUOP_ADD;
            end
            IMMWB: begin
                o_ctrl.regwrite = 1'b1;
            end
            JUMP: begin
                o_ctrl.pcsrc = PCSRC_JUMP;
                w_pcwrite    = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
        // BNE takes the branch when the operands differ.
        o_ctrl.pcen = w_pcwrite | (w_branch & (i_zero ^ w_is_bne));
    end

endmodule

// File: rtl/mc_maindec.sv
// -----------------------------------------------------------------------------
// mc_maindec
// Multicycle main controller (Moore FSM) for the MIPS core. Sequences
// fetch/decode/execute/memory/writeback for the shared-ALU, shared-memory
// datapath and counts retired instructions.
// Parameters: OP_W opcode width, EN_BNE / EN_ORI enable the optional opcodes,
//   MEM_HANDSHAKE makes memory states wait for i_mem_ready, CNT_W counter width.
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_op, i_zero, i_mem_ready   opcode, ALU zero flag, memory access done
//   o_pcen .. o_pcsrc           datapath control strobes and selects
//   o_illegal_op                unsupported opcode seen in DECODE
//   o_instr_cnt                 retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_maindec
    import mc_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int EN_BNE        = 1,
    parameter int EN_ORI        = 1,
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [OP_W-1:0]  i_op,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pcen,
    output logic             o_iord,
    output logic             o_memwrite,
    output logic             o_irwrite,
    output logic             o_regdst,
    output logic             o_memtoreg,
    output logic             o_regwrite,
    output logic             o_alusrca,
    output logic [1:0]       o_alusrcb,
    output logic [1:0]       o_aluop,
    output logic [1:0]       o_pcsrc,
    output logic             o_illegal_op,
    output logic [CNT_W-1:0] o_instr_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [5:0]       w_op6;
    logic             w_mr;
    logic             w_legal;
    logic             w_retire;
    ctrl_t            w_ctrl_dec;
    ctrl_t            w_ctrl_out;

    assign w_op6   = 6'(i_op);
    assign w_mr    = (MEM_HANDSHAKE != 0) ? i_mem_ready : 1'b1;
    assign w_legal = op_legal(w_op6, (EN_BNE != 0), (EN_ORI != 0));

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (w_mr) w_next = DECODE;
                else      w_next = FETCH;
            end
            DECODE: begin
                if (!w_legal) begin
                    w_next = FETCH;
                end else begin
                    case (w_op6)
                        OP_LW, OP_SW:    w_next = MEMADR;
                        OP_R:            w_next = RTYPEEX;
                        OP_BEQ, OP_BNE:  w_next = BRANCH;
                        OP_ADDI, OP_ORI: w_next = IMMEX;
                        OP_J:            w_next = JUMP;
                        default:         w_next = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                if (w_op6 == OP_LW) w_next = MEMRD;
                else                w_next = MEMWR;
            end
            MEMRD: begin
                if (w_mr) w_next = MEMWB;
                else      w_next = MEMRD;
            end
            MEMWR: begin
                if (w_mr) w_next = FETCH;
                else      w_next = MEMWR;
            end
            RTYPEEX: w_next = ALUWB;
            IMMEX:   w_next = IMMWB;
            MEMWB, ALUWB, IMMWB, BRANCH, JUMP: w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    // An instruction retires on its last cycle; illegal ops never get here.
    always_comb begin
        case (r_state)
            MEMWB, ALUWB, IMMWB, BRANCH, JUMP: w_retire = 1'b1;
            MEMWR:   w_retire = w_mr;
            default: w_retire = 1'b0;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= FETCH;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1'b1);
            else          r_instr_cnt <= r_instr_cnt;
        end
    end

    mc_outdec u_outdec (
        .i_state     (r_state),
        .i_op6       (w_op6),
        .i_legal     (w_legal),
        .i_zero      (i_zero),
        .i_mem_ready (w_mr),
        .o_ctrl      (w_ctrl_dec)
    );

    // Write strobes are forced low the moment reset asserts, so an in-flight
    // store is dropped without waiting for a clock edge.
    always_comb begin
        if (!i_reset_n) w_ctrl_out = ctrl_gate(w_ctrl_dec);
        else            w_ctrl_out = w_ctrl_dec;
    end

    assign o_pcen       = w_ctrl_out.pcen;
    assign o_iord       = w_ctrl_out.iord;
    assign o_memwrite   = w_ctrl_out.memwrite;
    assign o_irwrite    = w_ctrl_out.irwrite;
    assign o_regdst     = w_ctrl_out.regdst;
    assign o_memtoreg   = w_ctrl_out.memtoreg;
    assign o_regwrite   = w_ctrl_out.regwrite;
    assign o_alusrca    = w_ctrl_out.alusrca;
    assign o_alusrcb    = w_ctrl_out.alusrcb;
    assign o_aluop      = w_ctrl_out.aluop;
    assign o_pcsrc      = w_ctrl_out.pcsrc;
    assign o_illegal_op = w_ctrl_out.illegal_op;
    assign o_instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_mc_maindec.sv
// -----------------------------------------------------------------------------
// tb_mc_maindec
// Two controllers: u0 with all options on and a 16-bit counter, u1 with BNE/ORI
// disabled, memory handshake off and a 4-bit counter. Each has its own driver
// that builds the expected per-cycle control vector of every instruction from
// the instruction's cycle recipe and queues it; a monitor per instance pops
// one entry per cycle and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_maindec;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;

    typedef struct packed {
        logic [14:0] vec;
        logic [15:0] cnt;
        logic [5:0]  op;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, z0, mr0, rst1, z1, mr1;
    logic [5:0] op0, op1;
    logic       pcen0, iord0, mw0, irw0, rd0, m2r0, rw0, asa0, ill0;
    logic       pcen1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, ill1;
    logic [1:0] asb0, aop0, psrc0, asb1, aop1, psrc1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    logic [15:0] cnt_m [2];
    int n_cmp = 0;
    int n_bad = 0;

    mc_maindec u0 (
        .i_clk(clk), .i_reset_n(rst0), .i_op(op0), .i_zero(z0), .i_mem_ready(mr0),
        .o_pcen(pcen0), .o_iord(iord0), .o_memwrite(mw0), .o_irwrite(irw0),
        .o_regdst(rd0), .o_memtoreg(m2r0), .o_regwrite(rw0), .o_alusrca(asa0),
        .o_alusrcb(asb0), .o_aluop(aop0), .o_pcsrc(psrc0), .o_illegal_op(ill0),
        .o_instr_cnt(cnt0)
    );

    mc_maindec #(.EN_BNE(0), .EN_ORI(0), .MEM_HANDSHAKE(0), .CNT_W(4)) u1 (
        .i_clk(clk), .i_reset_n(rst1), .i_op(op1), .i_zero(z1), .i_mem_ready(mr1),
        .o_pcen(pcen1), .o_iord(iord1), .o_memwrite(mw1), .o_irwrite(irw1),
        .o_regdst(rd1), .o_memtoreg(m2r1), .o_regwrite(rw1), .o_alusrca(asa1),
        .o_alusrcb(asb1), .o_aluop(aop1), .o_pcsrc(psrc1), .o_illegal_op(ill1),
        .o_instr_cnt(cnt1)
    );

    function automatic logic [14:0] v(input logic pcen, iord, mw, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, aop, psrc, input logic ill);
        return {pcen, iord, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [5:0] op, input bit en_opt);
        if (op == T_R || op == T_J || op == T_BEQ || op == T_ADDI || op == T_LW || op == T_SW)
            return 1'b1;
        else if (op == T_BNE || op == T_ORI)
            return en_opt;
        else
            return 1'b0;
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 9))
            0: return T_R;
            1: return T_LW;
            2: return T_SW;
            3: return T_BEQ;
            4: return T_BNE;
            5: return T_ADDI;
            6: return T_ORI;
            7: return T_J;
            8: return 6'b000011;
            default: return 6'b111111;
        endcase
    endfunction

    task automatic check(input string nm, input logic [5:0] op, input logic [15:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s op=%b t=%0t: got %h want %h", nm, op, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus for instance idx, with its expected outputs.
    task automatic cycle(input int idx, input logic rst, input logic mr, input logic z,
                         input logic [5:0] op, input logic [14:0] ev, input logic [15:0] ec);
        exp_t e;
        e.vec = ev;
        e.cnt = ec;
        e.op  = op;
        @(posedge clk);
        #1;
        if (idx == 0) begin
            rst0 = rst; mr0 = mr; z0 = z; op0 = op;
            q0.push_back(e);
        end else begin
            rst1 = rst; mr1 = mr; z1 = z; op1 = op;
            q1.push_back(e);
        end
    endtask

    // Reset held for n cycles with mem_ready high: no strobe may leak out.
    task automatic reset_pulse(input int idx, input int n, input logic [5:0] op);
        for (int i = 0; i < n; i++)
            cycle(idx, 1'b0, 1'b1, rb(), op, v(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 16'd0);
        cnt_m[idx] = 16'd0;
    endtask

    task automatic run_instr(input int idx, input logic [5:0] op, input logic z,
                             input int fstall, input int mstall, input bit abort);
        bit          hs, leg;
        logic [15:0] c;
        logic [1:0]  aop;
        logic [14:0] mv;
        hs  = (idx == 0);
        leg = legal(op, idx == 0);
        c   = cnt_m[idx];
        // Fetch, waiting on memory when the handshake is in use.
        for (int i = 0; i < (hs ? fstall : 0); i++)
            cycle(idx, 1'b1, 1'b0, rb(), op, v(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), c);
        cycle(idx, 1'b1, hs ? 1'b1 : rb(), rb(), op, v(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), c);
        // Decode.
        cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!leg), c);
        if (!leg) return;
        if (op == T_LW || op == T_SW) begin
            cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), c);
            mv = v(0,1,op == T_SW,0,0,0,0,0,2'b00,2'b00,2'b00,0);
            for (int i = 0; i < (hs ? mstall : 0); i++)
                cycle(idx, 1'b1, 1'b0, rb(), op, mv, c);
            if (abort && op == T_SW) begin
                reset_pulse(idx, 2, op);
                return;
            end
            cycle(idx, 1'b1, hs ? 1'b1 : rb(), rb(), op, mv, c);
            if (op == T_LW)
                cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), c);
        end else if (op == T_R) begin
            cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), c);
            cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), c);
        end else if (op == T_BEQ || op == T_BNE) begin
            cycle(idx, 1'b1, rb(), z, op,
                  v(z ^ (op == T_BNE),0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), c);
        end else if (op == T_ADDI || op == T_ORI) begin
            aop = (op == T_ORI) ? 2'b11 : 2'b00;
            cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,0,0,0,1,2'b10,aop,2'b00,0), c);
            cycle(idx, 1'b1, rb(), rb(), op, v(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), c);
        end else begin
            cycle(idx, 1'b1, rb(), rb(), op, v(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), c);
        end
        if (idx == 0) cnt_m[idx] = c + 16'd1;
        else          cnt_m[idx] = (c + 16'd1) & 16'h000f;
    endtask

    always @(negedge clk) begin
        if (q0.size() != 0) begin
            m0 = q0.pop_front();
            check("u0_ctrl", m0.op,
                  {1'b0, pcen0, iord0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, aop0, psrc0, ill0},
                  {1'b0, m0.vec});
            check("u0_cnt", m0.op, cnt0, m0.cnt);
        end
    end

    always @(negedge clk) begin
        if (q1.size() != 0) begin
            m1 = q1.pop_front();
            check("u1_ctrl", m1.op,
                  {1'b0, pcen1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, psrc1, ill1},
                  {1'b0, m1.vec});
            check("u1_cnt", m1.op, {12'd0, cnt1}, m1.cnt);
        end
    end

    initial begin
        rst0 = 1'b0; mr0 = 1'b1; z0 = 1'b0; op0 = T_R;
        rst1 = 1'b0; mr1 = 1'b1; z1 = 1'b0; op1 = T_R;
        cnt_m[0] = 16'd0;
        cnt_m[1] = 16'd0;
        fork
            begin
                reset_pulse(0, 2, T_R);
                run_instr(0, T_LW,   1'b0, 0, 0, 1'b0);
                run_instr(0, T_SW,   1'b0, 0, 3, 1'b0);
                run_instr(0, T_ADDI, 1'b0, 2, 0, 1'b0);
                run_instr(0, T_BNE,  1'b0, 0, 0, 1'b0);
                run_instr(0, T_BNE,  1'b1, 0, 0, 1'b0);
                run_instr(0, T_ORI,  1'b0, 0, 0, 1'b0);
                run_instr(0, T_BEQ,  1'b1, 1, 0, 1'b0);
                run_instr(0, T_LW,   1'b0, 0, 2, 1'b0);
                run_instr(0, T_R,    1'b0, 0, 0, 1'b0);
                run_instr(0, T_J,    1'b0, 0, 0, 1'b0);
                run_instr(0, T_SW,   1'b0, 0, 2, 1'b1);
                run_instr(0, T_J,    1'b0, 0, 0, 1'b0);
                for (int k = 0; k < 60; k++)
                    run_instr(0, pick_op(), rb(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
            end
            begin
                reset_pulse(1, 2, T_R);
                for (int k = 0; k < 16; k++)
                    run_instr(1, T_J, 1'b0, 0, 0, 1'b0);
                run_instr(1, T_BNE,  1'b0, 0, 0, 1'b0);
                run_instr(1, T_ORI,  1'b0, 0, 0, 1'b0);
                run_instr(1, T_ADDI, 1'b0, 0, 0, 1'b0);
                run_instr(1, T_LW,   1'b0, 0, 0, 1'b0);
                for (int k = 0; k < 60; k++)
                    run_instr(1, pick_op(), rb(), 0, 0, 1'b0);
            end
        join
        repeat (3) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d entries left want 0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
